// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sequencing NREQ requesters onto one i2c_master.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   req_i/req_op_i        per-requester level request and op (1 = read)
//   req_addr_i/req_din_i  per-requester 7-bit address / 8-bit write byte, packed by index
//   gnt_o                 one-hot grant, held from grant through the response cycle
//   rsp_valid_o           one-cycle pulse on the granted bit with rsp_data_o / rsp_err_o
//   m_*_o / m_*_i         command and status handshake with the shared i2c_master
//   timeout_err_o         one-cycle watchdog pulse, coincident with rsp_valid_o
// Option: define I2C_ARB_TIMEOUT_EN to enable the WAIT watchdog (limit TIMEOUT cycles).
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   req_op_i,
  input  logic [7*NREQ-1:0] req_addr_i,
  input  logic [8*NREQ-1:0] req_din_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [7:0]        rsp_data_o,
  output logic              rsp_err_o,
  output logic              m_newd_o,
  output logic              m_op_o,
  output logic [6:0]        m_addr_o,
  output logic [7:0]        m_din_o,
  input  logic [7:0]        m_dout_i,
  input  logic              m_ack_err_i,
  input  logic              m_done_i,
  input  logic              m_busy_i,
  output logic              timeout_err_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          state_q;
  logic [IW-1:0]   ptr_q, g_q, pick_d;
  logic [NREQ-1:0] gnt_q, rsp_valid_q;
  logic [7:0]      rsp_data_q, m_din_q;
  logic [6:0]      m_addr_q;
  logic            rsp_err_q, m_newd_q, m_op_q;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_q;
  logic          timeout_q;
  assign timeout_err_o = timeout_q;
`else
  // watchdog compiled out: the pulse is constant low
  assign timeout_err_o = 1'b0 & (TIMEOUT > 0);
`endif
  // first pending requester at or above ptr, wrapping; iterating downward lets the
  // lowest rotated offset win
  always_comb begin
    pick_d = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_q) + k) % NREQ]) pick_d = IW'((int'(ptr_q) + k) % NREQ);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      m_newd_q    <= 1'b0;
      m_op_q      <= 1'b0;
      m_addr_q    <= '0;
      m_din_q     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      m_newd_q    <= 1'b0;
      rsp_valid_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: if (|req_i && !m_busy_i) begin
          g_q      <= pick_d;
          gnt_q    <= NREQ'(1) << pick_d;
          m_op_q   <= req_op_i[pick_d];
          m_addr_q <= req_addr_i[7*pick_d +: 7];
          m_din_q  <= req_din_i[8*pick_d +: 8];
          m_newd_q <= 1'b1;
          state_q  <= ISSUE;
        end
        // m_done is not looked at here, so a stale done from the master is ignored
        ISSUE: begin
          state_q <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        WAIT: if (m_done_i) begin
          rsp_data_q  <= m_dout_i;
          rsp_err_q   <= m_ack_err_i;
          rsp_valid_q <= gnt_q;
          state_q     <= RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wd_q == CW'(TIMEOUT - 1)) begin
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= gnt_q;
          timeout_q   <= 1'b1;
          state_q     <= RESP;
        end else wd_q <= wd_q + 1'b1;
`endif
        default: begin
          gnt_q   <= '0;
          ptr_q   <= (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign m_newd_o    = m_newd_q;
  assign m_op_o      = m_op_q;
  assign m_addr_o    = m_addr_q;
  assign m_din_o     = m_din_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized self-checking bench for i2c_req_arbiter with a round-robin reference model.
module tb_i2c_req_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, req_op = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_din = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [7:0] rsp_data, m_din, m_dout = '0;
  logic [6:0] m_addr;
  logic rsp_err, m_newd, m_op, timeout_err;
  logic m_ack_err = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  int checks = 0, failures = 0;
  int exp_ptr = 0;
  always #5 clk = ~clk;
  i2c_req_arbiter #(.NREQ(N), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_din_i(req_din), .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .m_newd_o(m_newd), .m_op_o(m_op), .m_addr_o(m_addr), .m_din_o(m_din),
    .m_dout_i(m_dout), .m_ack_err_i(m_ack_err), .m_done_i(m_done), .m_busy_i(m_busy),
    .timeout_err_o(timeout_err));
  // reference rule: first pending index searching upward from p, wrapping
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic set_cmd(input int i, input logic op, input logic [6:0] a, input logic [7:0] d);
    req_op[i] = op;
    req_addr[7*i +: 7] = a;
    req_din[8*i +: 8] = d;
  endtask
  // Master stand-in: waits for m_newd, optionally pulses a stale done during ISSUE, answers after
  // lat WAIT cycles, and reports what the arbiter showed. Returns on the first IDLE negedge.
  task automatic serve(input int lat, input bit early, input bit drop, input logic [7:0] dout,
                       input logic err, output int tw, output logic [N-1:0] g, output logic [15:0] cmd,
                       output logic [13:0] rsp, output logic [N-1:0] rv2, output bit hold);
    int t = 0;
    g = '0; cmd = '0; rsp = '0; rv2 = '0; hold = 1'b1;
    while (m_newd !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    tw = t;
    if (m_newd !== 1'b1) return;
    g = gnt;
    cmd = {m_op, m_addr, m_din};
    if (early) m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    if (drop) req = '0;
    repeat (lat) begin
      hold &= ({m_op, m_addr, m_din} === cmd && rsp_valid === '0 && gnt === g);
      @(negedge clk);
    end
    m_dout = dout; m_ack_err = err; m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0; m_dout = 8'($urandom); m_ack_err = 1'($urandom);
    rsp = {rsp_valid, rsp_data, rsp_err, timeout_err};
    hold &= ({m_op, m_addr, m_din} === cmd && gnt === g);
    @(negedge clk);
    rv2 = rsp_valid;
    hold &= (rsp_data === rsp[9:2] && rsp_err === rsp[1] && gnt === '0);
  endtask
  task automatic test_reset;
    req = '1; m_done = 1'b1; m_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, m_newd, m_op, m_addr, m_din, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_values: got gnt=%b rv=%b data=%h err=%b newd=%b op=%b addr=%h din=%h to=%b want all zero",
               gnt, rsp_valid, rsp_data, rsp_err, m_newd, m_op, m_addr, m_din, timeout_err);
    end
    req = '0; m_done = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== '0 || m_newd !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got gnt=%b newd=%b want 0000/0", gnt, m_newd);
    end
    exp_ptr = 0;
  endtask
  task automatic test_single_write;
    int tw; logic [N-1:0] g, rv2; logic [15:0] cmd; logic [13:0] rsp; bit hold;
    set_cmd(2, 1'b0, 7'h50, 8'hA5);
    req = 4'b0100;
    serve(3, 1'b0, 1'b0, 8'hFF, 1'b0, tw, g, cmd, rsp, rv2, hold);
    req = '0;
    checks++;
    if (tw !== 1 || g !== 4'b0100 || cmd !== {1'b0, 7'h50, 8'hA5}) begin
      failures++;
      $display("FAIL single_issue: got lat=%0d gnt=%b cmd=%h want 1/0100/%h", tw, g, cmd, {1'b0, 7'h50, 8'hA5});
    end
    checks++;
    if (rsp !== {4'b0100, 8'hFF, 1'b0, 1'b0} || rv2 !== '0 || !hold) begin
      failures++;
      $display("FAIL single_resp: got rsp=%h rv2=%b hold=%0d want %h/0000/1", rsp, rv2, hold, {4'b0100, 8'hFF, 2'b00});
    end
    exp_ptr = 3;
  endtask
  task automatic test_round_robin;
    int tw; logic [N-1:0] g, rv2; logic [15:0] cmd; logic [13:0] rsp; bit hold;
    int ord[7] = '{0, 1, 2, 3, 0, 3, 0};
    logic [15:0] ecmd;
    rst = 1'b0; @(negedge clk); rst = 1'b1; exp_ptr = 0;
    for (int i = 0; i < N; i++) set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) req = 4'b1001;
      ecmd = {req_op[ord[i]], req_addr[7*ord[i] +: 7], req_din[8*ord[i] +: 8]};
      serve($urandom_range(3, 0), 1'b0, 1'b0, 8'(i + 1), 1'b0, tw, g, cmd, rsp, rv2, hold);
      checks++;
      if (g !== N'(1) << ord[i] || cmd !== ecmd || rsp[13:10] !== g || rv2 !== '0 || !hold) begin
        failures++;
        $display("FAIL rr_order[%0d]: got gnt=%b cmd=%h rv=%b want gnt=%b cmd=%h", i, g, cmd, rsp[13:10],
                 N'(1) << ord[i], ecmd);
      end
      exp_ptr = (ord[i] + 1) % N;
    end
    req = '0;
  endtask
  task automatic test_read_err;
    int tw; logic [N-1:0] g, rv2; logic [15:0] cmd; logic [13:0] rsp; bit hold;
    set_cmd(3, 1'b1, 7'h2B, 8'h00);
    req = 4'b1000;
    m_dout = 8'h77;
    serve(2, 1'b1, 1'b0, 8'h3C, 1'b1, tw, g, cmd, rsp, rv2, hold);
    req = '0;
    checks++;
    if (g !== 4'b1000 || cmd !== {1'b1, 7'h2B, 8'h00}) begin
      failures++;
      $display("FAIL read_issue: got gnt=%b cmd=%h want 1000/%h", g, cmd, {1'b1, 7'h2B, 8'h00});
    end
    checks++;
    if (rsp !== {4'b1000, 8'h3C, 1'b1, 1'b0} || rv2 !== '0 || !hold) begin
      failures++;
      $display("FAIL read_err_resp: got rsp=%h rv2=%b hold=%0d want %h/0000/1", rsp, rv2, hold, {4'b1000, 8'h3C, 2'b10});
    end
    exp_ptr = 0;
  endtask
  task automatic test_withdraw_drop;
    int tw; logic [N-1:0] g, rv2; logic [15:0] cmd; logic [13:0] rsp; bit hold, quiet;
    set_cmd(0, 1'b0, 7'h11, 8'h22);
    set_cmd(1, 1'b1, 7'h33, 8'h44);
    m_busy = 1'b1;
    req = 4'b0011;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== '0 || m_newd !== 1'b0) begin
      failures++;
      $display("FAIL busy_hold: got gnt=%b newd=%b want 0000/0", gnt, m_newd);
    end
    req[1] = 1'b0;
    m_busy = 1'b0;
    serve(2, 1'b0, 1'b1, 8'h5A, 1'b0, tw, g, cmd, rsp, rv2, hold);
    checks++;
    if (g !== 4'b0001 || cmd !== {1'b0, 7'h11, 8'h22} || rsp !== {4'b0001, 8'h5A, 2'b00} || !hold) begin
      failures++;
      $display("FAIL late_drop: got gnt=%b cmd=%h rsp=%h hold=%0d want 0001/%h/%h/1", g, cmd, rsp, hold,
               {1'b0, 7'h11, 8'h22}, {4'b0001, 8'h5A, 2'b00});
    end
    quiet = 1'b1;
    repeat (5) begin quiet &= (gnt === '0 && m_newd === 1'b0 && rsp_valid === '0); @(negedge clk); end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL withdrawn_granted: got activity=1 want activity=0");
    end
    exp_ptr = 1;
  endtask
  task automatic test_reset_in_wait;
    int tw, t; logic [N-1:0] g, rv2; logic [15:0] cmd; logic [13:0] rsp; bit hold;
    set_cmd(2, 1'b0, 7'h6E, 8'h81);
    set_cmd(0, 1'b1, 7'h05, 8'h09);
    set_cmd(3, 1'b0, 7'h7F, 8'hF0);
    req = 4'b0100;
    serve(1, 1'b0, 1'b0, 8'hC3, 1'b1, tw, g, cmd, rsp, rv2, hold);
    t = 0;
    while (m_newd !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    checks++;
    if (gnt !== 4'b0100 || m_newd !== 1'b1) begin
      failures++;
      $display("FAIL regrant_before_reset: got gnt=%b newd=%b want 0100/1", gnt, m_newd);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, m_newd, m_op, m_addr, m_din, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_in_wait: got gnt=%b rv=%b data=%h err=%b newd=%b addr=%h din=%h want all zero",
               gnt, rsp_valid, rsp_data, rsp_err, m_newd, m_addr, m_din);
    end
    rst = 1'b1;
    req = 4'b1001;
    exp_ptr = 0;
    serve(0, 1'b0, 1'b0, 8'h4D, 1'b0, tw, g, cmd, rsp, rv2, hold);
    req = '0;
    checks++;
    if (g !== 4'b0001 || cmd !== {1'b1, 7'h05, 8'h09} || rsp !== {4'b0001, 8'h4D, 2'b00} || !hold) begin
      failures++;
      $display("FAIL ptr_after_reset: got gnt=%b cmd=%h rsp=%h want 0001/%h/%h", g, cmd, rsp,
               {1'b1, 7'h05, 8'h09}, {4'b0001, 8'h4D, 2'b00});
    end
    exp_ptr = 1;
  endtask
  task automatic test_random;
    int tw, e, age[N], worst;
    logic [N-1:0] g, rv2; logic [15:0] cmd, ecmd; logic [13:0] rsp; bit hold;
    logic [7:0] dout; logic err;
    int bad = 0;
    for (int i = 0; i < N; i++) age[i] = 0;
    worst = 0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          set_cmd(i, 1'($urandom), 7'($urandom), 8'($urandom));
          req[i] = 1'b1; age[i] = 0;
        end
      if (req == '0) begin set_cmd(0, 1'($urandom), 7'($urandom), 8'($urandom)); req[0] = 1'b1; age[0] = 0; end
      e = rr_pick(req, exp_ptr);
      ecmd = {req_op[e], req_addr[7*e +: 7], req_din[8*e +: 8]};
      dout = 8'($urandom); err = 1'($urandom);
      serve($urandom_range(4, 0), bit'($urandom_range(1, 0)), 1'b0, dout, err, tw, g, cmd, rsp, rv2, hold);
      checks++;
      if (tw !== 1 || g !== N'(1) << e || cmd !== ecmd || rsp !== {N'(1) << e, dout, err, 1'b0} || rv2 !== '0 || !hold) begin
        failures++; bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: got lat=%0d gnt=%b cmd=%h rsp=%h rv2=%b hold=%0d want 1/%b/%h/%h/0000/1",
                   it, tw, g, cmd, rsp, rv2, hold, N'(1) << e, ecmd, {N'(1) << e, dout, err, 1'b0});
      end
      req[e] = 1'b0;
      exp_ptr = (e + 1) % N;
      for (int i = 0; i < N; i++) if (req[i]) begin age[i]++; if (age[i] > worst) worst = age[i]; end
    end
    req = '0;
    checks++;
    if (worst > N - 1) begin
      failures++;
      $display("FAIL fairness: got max wait=%0d transactions want <=%0d", worst, N - 1);
    end
  endtask
`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int t = 0, n = 0;
    set_cmd(1, 1'b1, 7'h42, 8'h00);
    req = 4'b0010;
    while (m_newd !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    req = '0;
    while (rsp_valid === '0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 17 || rsp_valid !== 4'b0010 || rsp_data !== 8'h00 || rsp_err !== 1'b1 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout: got cycles=%0d rv=%b data=%h err=%b to=%b want 17/0010/00/1/1",
               n, rsp_valid, rsp_data, rsp_err, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || rsp_valid !== '0 || gnt !== '0) begin
      failures++;
      $display("FAIL timeout_pulse: got to=%b rv=%b gnt=%b want 0/0000/0000", timeout_err, rsp_valid, gnt);
    end
    exp_ptr = 2;
  endtask
`endif
  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_read_err;
    test_withdraw_drop;
    test_reset_in_wait;
    test_random;
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
